// File: rtl/if_id_register.sv
// if_id_register: two-entry skid-buffered IF/ID pipeline register with valid/ready handshake and flush
// Build option: define IF_ID_PERF_CNT_EN to add the stall_cycles/flush_count performance counters.
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   flush                          drop both entries at the next edge
//   in_valid/in_ready              fetch-side handshake; in_ready is the inverse of skid occupancy
//   in_pc, in_inst, in_pc4         fetched instruction fields
//   out_valid/out_ready            decode-side handshake
//   out_pc, out_inst, out_pc4      main-entry fields; out_inst is NOP_INST while out_valid=0
//   stall_cycles, flush_count      performance counters (IF_ID_PERF_CNT_EN builds only)
module if_id_register #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic [63:0] in_pc4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc4
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    logic        m_valid, s_valid;
    logic [63:0] m_pc, m_pc4, s_pc, s_pc4;
    logic [31:0] m_inst, s_inst;
    logic        in_xfer, adv;

    // in_ready comes straight from the skid flop, so out_ready never reaches fetch combinationally
    assign in_ready  = !s_valid;
    assign in_xfer   = in_valid && !s_valid;
    // main entry can take new data when empty or being consumed this edge
    assign adv       = !m_valid || out_ready;
    assign out_valid = m_valid;
    assign out_pc    = m_pc;
    assign out_pc4   = m_pc4;
    assign out_inst  = m_valid ? m_inst : NOP_INST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_inst  <= '0;
            m_pc4   <= '0;
            s_valid <= 1'b0;
            s_pc    <= '0;
            s_inst  <= '0;
            s_pc4   <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (adv) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_pc    <= s_pc;
                m_inst  <= s_inst;
                m_pc4   <= s_pc4;
                s_valid <= in_xfer;
                if (in_xfer) begin
                    s_pc   <= in_pc;
                    s_inst <= in_inst;
                    s_pc4  <= in_pc4;
                end
            end else begin
                m_valid <= in_xfer;
                if (in_xfer) begin
                    m_pc   <= in_pc;
                    m_inst <= in_inst;
                    m_pc4  <= in_pc4;
                end
            end
        end else if (in_xfer) begin
            s_valid <= 1'b1;
            s_pc    <= in_pc;
            s_inst  <= in_inst;
            s_pc4   <= in_pc4;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (in_valid && s_valid && stall_cycles != 32'hFFFFFFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush && (m_valid || s_valid))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_register.sv
// tb_if_id_register: directed and randomized checks of if_id_register against a queue-based FIFO model
module tb_if_id_register;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] pc4;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc4 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [63:0] out_pc4;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    ent_t        q[$];
    ent_t        last;
    logic [31:0] m_stall;
    logic [15:0] m_flush;

    if_id_register dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_inst(in_inst),
        .in_pc4(in_pc4),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .out_pc4(out_pc4)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic ent_t mk(input logic [63:0] pc);
        ent_t e;
        e.pc   = pc;
        e.inst = 32'h00100093 + pc[31:0];
        e.pc4  = pc + 64'd1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({tag, " in_ready"}, 64'(in_ready), 64'(q.size() < 2));
        chk({tag, " out_inst"}, 64'(out_inst), 64'(q.size() > 0 ? q[0].inst : NOP));
        chk({tag, " out_pc"}, out_pc, last.pc);
        chk({tag, " out_pc4"}, out_pc4, last.pc4);
`ifdef IF_ID_PERF_CNT_EN
        chk({tag, " stall_cycles"}, 64'(stall_cycles), 64'(m_stall));
        chk({tag, " flush_count"}, 64'(flush_count), 64'(m_flush));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        last    = '{pc: '0, inst: '0, pc4: '0};
        m_stall = '0;
        m_flush = '0;
    endtask

    // Drive one cycle of inputs, advance the FIFO model by the same edge, then check after the edge.
    task automatic cyc(input string tag, input logic v, input ent_t e, input logic ordy, input logic fl);
        logic rdy;
        in_valid  = v;
        in_pc     = e.pc;
        in_inst   = e.inst;
        in_pc4    = e.pc4;
        out_ready = ordy;
        flush     = fl;
        rdy = q.size() < 2;
        if (v && !rdy && m_stall != 32'hFFFFFFFF) m_stall++;
        if (fl) begin
            if (q.size() > 0) m_flush++;
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && rdy) q.push_back(e);
        end
        if (q.size() > 0) last = q[0];
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        ent_t z;
        ent_t e;
        z = mk(64'd0);
        model_reset();

        // reset then idle
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset out_inst nop", 64'(out_inst), 64'h13);
        @(negedge clk) rst = 1'b1;
        cyc("idle", 1'b0, z, 1'b1, 1'b0);

        // perf counters: 5 stalls, 2 flushes with data, 1 flush while empty
        cyc("perf fill0", 1'b1, mk(64'd100), 1'b0, 1'b0);
        cyc("perf fill1", 1'b1, mk(64'd101), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("perf stall", 1'b1, mk(64'd102), 1'b0, 1'b0);
        cyc("perf flush1", 1'b0, z, 1'b0, 1'b1);
        cyc("perf load", 1'b1, mk(64'd103), 1'b0, 1'b0);
        cyc("perf flush2", 1'b0, z, 1'b0, 1'b1);
        cyc("perf flush empty", 1'b0, z, 1'b0, 1'b1);
`ifdef IF_ID_PERF_CNT_EN
        chk("perf stall_cycles=5", 64'(stall_cycles), 64'd5);
        chk("perf flush_count=2", 64'(flush_count), 64'd2);
`endif

        // streaming pc 0..7 at full rate, then drain
        for (int k = 0; k < 8; k++) cyc("stream", 1'b1, mk(64'(k)), 1'b1, 1'b0);
        chk("stream last out_pc", out_pc, 64'd7);
        cyc("stream drain", 1'b0, z, 1'b1, 1'b0);

        // backpressure: pc0 in main, pc1 in skid, pc2 held by fetch
        cyc("bp 0", 1'b1, mk(64'd0), 1'b0, 1'b0);
        cyc("bp 1", 1'b1, mk(64'd1), 1'b0, 1'b0);
        cyc("bp 2 held", 1'b1, mk(64'd2), 1'b0, 1'b0);
        chk("bp in_ready low", 64'(in_ready), 64'd0);
        chk("bp main pc0", out_pc, 64'd0);
        cyc("bp release", 1'b1, mk(64'd2), 1'b1, 1'b0);
        chk("bp out pc1", out_pc, 64'd1);
        cyc("bp accept 2", 1'b1, mk(64'd2), 1'b1, 1'b0);
        cyc("bp drain", 1'b0, z, 1'b1, 1'b0);
        cyc("bp empty", 1'b0, z, 1'b1, 1'b0);

        // flush while full, with pc6 presented in the same cycle
        cyc("fl 4", 1'b1, mk(64'd4), 1'b0, 1'b0);
        cyc("fl 5", 1'b1, mk(64'd5), 1'b0, 1'b0);
        cyc("fl flush", 1'b1, mk(64'd6), 1'b0, 1'b1);
        chk("fl out_valid", 64'(out_valid), 64'd0);
        chk("fl in_ready", 64'(in_ready), 64'd1);
        cyc("fl 20", 1'b1, mk(64'd20), 1'b1, 1'b0);
        chk("fl out_pc 20", out_pc, 64'd20);
        cyc("fl drain", 1'b0, z, 1'b1, 1'b0);

        // asynchronous reset between edges while full
        cyc("ar 8", 1'b1, mk(64'd8), 1'b0, 1'b0);
        cyc("ar 9", 1'b1, mk(64'd9), 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("ar out_valid immediate", 64'(out_valid), 64'd0);
        check_all("ar during");
        @(negedge clk) rst = 1'b1;
        cyc("ar 30", 1'b1, mk(64'd30), 1'b1, 1'b0);
        chk("ar first out pc30", out_pc, 64'd30);
        cyc("ar drain", 1'b0, z, 1'b1, 1'b0);

        // randomized traffic against the FIFO model
        for (int i = 0; i < 400; i++) begin
            e.pc   = {$urandom, $urandom};
            e.inst = $urandom;
            e.pc4  = e.pc + 64'd1;
            cyc("rand", $urandom_range(0, 3) != 0, e, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
